chipset_noc_traffic_gen: RTL and testbench
==========================================

# chipset_noc_traffic_gen

Parametrised NoC traffic generator and response checker for the Polara chipset side. It drives a configurable burst of packets (header plus optional payload flits) into one chip-bound NoC channel with the standard valid/ready handshake. It sinks and checks the returning packets on one chip-to-chipset channel, then reports counts, errors and a pass flag. It is instantiated once per NoC under test alongside the chip reset/FLL control logic, replacing fixed single-packet bring-up stimulus.

## Interface
Parameters:
- NOC_DATA_WIDTH, 64, flit width; header layout fixed in the top 64 bits, upper bits zero.
- NUM_PKTS, 16, packets per run, 1..65535.
- PAYLOAD_FLITS, 0, payload flits per packet, 0..255; also written into the header length field.
- GAP_CYCLES, 0, idle cycles inserted between packets, 0..255.
- TX_MSG_TYPE, 8'd18, message type of generated headers.
- EXP_RX_MSG_TYPE, 8'd18, expected message type of returned headers.
- DEST_CHIPID, 14'b10000000000000, header CHIPID field; XPOS = YPOS = 0, FBITS = 4'b0010.
- EXPECT_RESP, 1, 1 = wait for NUM_PKTS returned packets; 0 = finish after the last transmitted flit.
- TIMEOUT_CYCLES, 1024, maximum idle rx cycles in DRAIN before failing, 1..65535.

Ports:
- chipset_clk, in, 1, sole clock.
- chipset_rst_n, in, 1, reset, synchronous, active-low.
- start, in, 1, single-cycle pulse that launches a run; ignored unless in IDLE or DONE.
- tx_data, out, NOC_DATA_WIDTH, flit toward the chip.
- tx_val, out, 1, tx flit valid.
- tx_rdy, in, 1, chip ready to accept.
- rx_data, in, NOC_DATA_WIDTH, flit from the chip.
- rx_val, in, 1, rx flit valid.
- rx_rdy, out, 1, generator ready to accept.
- busy, out, 1, run in progress.
- done, out, 1, run finished; held until next start or reset.
- pass, out, 1, valid when done; 1 = no errors and no timeout.
- timeout, out, 1, DRAIN timer expired.
- sent_count, out, 16, packets fully transmitted.
- recv_count, out, 16, packets fully received.
- err_count, out, 16, saturating count of header mismatches.

## Operation
- Header flit of packet p: {DEST_CHIPID, 8'd0, 8'd0, 4'b0010, PAYLOAD_FLITS[7:0], TX_MSG_TYPE, p[7:0] (MSHR field), 6'd0}.
- Payload flit k of packet p: {p[15:0], k[15:0]}, zero-extended to NOC_DATA_WIDTH.
- TX FSM states:
  - IDLE: go to HDR on start.
  - HDR: on handshake, go to PAY if PAYLOAD_FLITS>0. Otherwise end the packet.
  - PAY: on the handshake of the last payload flit, end the packet.
  - End of packet: sent_count++. If packets remain, go to GAP (when GAP_CYCLES>0) or HDR. Otherwise go to DRAIN (EXPECT_RESP=1) or DONE.
  - GAP: count GAP_CYCLES cycles, then go to HDR.
  - DRAIN: go to DONE when recv_count==NUM_PKTS, or on timeout.
  - DONE: on start, clear all counters and flags and go to HDR.
- RX parser (independent, active whenever busy):
  - RX_HDR: accept a flit, latch its length field L, compare msg type against EXP_RX_MSG_TYPE and MSHR against the expected index r[7:0] (in-order). On mismatch, err_count++ (saturating at 16'hFFFF). If L>0 go to RX_PAY, otherwise end the packet.
  - RX_PAY: skip L flits, then end the packet.
  - End of packet: recv_count++ and r++.
- rx_rdy = busy. Flits presented while not busy are not accepted and are not counted.
- Flits beyond NUM_PKTS packets while still busy: accepted, and err_count++ per extra header.
- pass = done & ~timeout & (err_count==0) & (recv_count==NUM_PKTS or EXPECT_RESP==0).

## Timing
- All outputs come from registers or decode of registered state only. There is no combinational path from tx_rdy to tx_val or from rx_val to rx_rdy.
- Reset values: tx_val=0, tx_data=0, rx_rdy=0, busy=0, done=0, pass=0, timeout=0, all counts 0, both FSMs idle. Reset asserted mid-run aborts immediately to these values.
- Transfer occurs on a cycle with val&rdy. tx_val and tx_data stay stable until that handshake. Back-to-back flits are emitted with zero bubbles while tx_rdy=1.
- The start pulse in cycle N gives busy=1 and tx_val=1 (header 0) in cycle N+1.
- Inter-packet spacing with tx_rdy held at 1: exactly GAP_CYCLES cycles with tx_val=0.
- The timeout counter resets on every accepted rx flit and increments only in DRAIN. It expires after TIMEOUT_CYCLES consecutive idle cycles; done and timeout assert the next cycle.
- In DONE, a start arriving on the same cycle as an rx flit: the run restarts and the flit is not counted.
- done rises one cycle after the final terminating event, in the same cycle busy falls.

## Test plan
- Default params, loopback bench returning each packet unchanged after 3 cycles: sent=recv=16, err=0, pass=1. tx headers carry MSHR 0..15 and length 0.
- PAYLOAD_FLITS=2, GAP_CYCLES=3, tx_rdy toggling every cycle: each packet is 3 flits with payload {p,0} and {p,1}, no flit is dropped or duplicated, and there are ≥3 idle cycles between packets.
- Bench swaps the returned packets 4 and 5: err_count=2, recv=16, pass=0.
- Bench returns only 10 packets with TIMEOUT_CYCLES=50: timeout=1 exactly 50 cycles after the last rx flit, and pass=0.
- EXPECT_RESP=0, NUM_PKTS=1: done 1 cycle after the header handshake, pass=1, and rx_rdy=0 afterward.
- Reset asserted mid-payload, then a start pulse: all outputs return to their reset values the next cycle, and the new run starts again at MSHR 0.

Source files
------------

// File: rtl/chipset_noc_traffic_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : chipset_noc_traffic_gen_if
// Purpose  : Bundles the two NoC channels used by the traffic generator.
//            tx_* carries flits from the chipset toward the chip.
//            rx_* carries flits from the chip back to the chipset.
// Modports : master - generator side (drives tx_data/tx_val and rx_rdy)
//            slave  - chip/bench side (drives tx_rdy and rx_data/rx_val)
// Revision : 1.0 - initial release
// ============================================================================
interface chipset_noc_traffic_gen_if #(
  parameter int NOC_DATA_WIDTH = 64
);
  logic [NOC_DATA_WIDTH-1:0] tx_data;
  logic                      tx_val;
  logic                      tx_rdy;
  logic [NOC_DATA_WIDTH-1:0] rx_data;
  logic                      rx_val;
  logic                      rx_rdy;

  modport master (
    output tx_data, tx_val,
    input  tx_rdy,
    input  rx_data, rx_val,
    output rx_rdy
  );

  modport slave (
    input  tx_data, tx_val,
    output tx_rdy,
    output rx_data, rx_val,
    input  rx_rdy
  );
endinterface
`default_nettype wire

// File: rtl/chipset_noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : chipset_noc_traffic_gen
// Purpose  : NoC traffic generator and response checker. Sends NUM_PKTS
//            packets (header + PAYLOAD_FLITS payload flits) on the tx
//            channel, parses returned packets on the rx channel and reports
//            counts, header errors, timeout and an overall pass flag.
// Ports    : chipset_clk    - clock
//            chipset_rst_n  - synchronous active-low reset
//            start          - run launch pulse (honoured in IDLE/DONE only)
//            noc            - tx/rx flit channels (master modport)
//            busy/done      - run in progress / run finished (held)
//            pass/timeout   - result flags, valid with done
//            sent_count, recv_count, err_count - 16-bit statistics
// Revision : 1.0 - initial release
// ============================================================================
module chipset_noc_traffic_gen #(
  parameter int          NOC_DATA_WIDTH  = 64,
  parameter int          NUM_PKTS        = 16,
  parameter int          PAYLOAD_FLITS   = 0,
  parameter int          GAP_CYCLES      = 0,
  parameter logic [7:0]  TX_MSG_TYPE     = 8'd18,
  parameter logic [7:0]  EXP_RX_MSG_TYPE = 8'd18,
  parameter logic [13:0] DEST_CHIPID     = 14'b10000000000000,
  parameter int          EXPECT_RESP     = 1,
  parameter int          TIMEOUT_CYCLES  = 1024
) (
  input  logic                      chipset_clk,
  input  logic                      chipset_rst_n,
  input  logic                      start,
  chipset_noc_traffic_gen_if.master noc,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               sent_count,
  output logic [15:0]               recv_count,
  output logic [15:0]               err_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_PAY   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [0:0] RX_HDR = 1'b0;
  localparam logic [0:0] RX_PAY = 1'b1;

  localparam logic [15:0] c_num_pkts = 16'(NUM_PKTS);
  localparam logic [15:0] c_last_pkt = 16'(NUM_PKTS - 1);
  localparam logic [7:0]  c_pay_len  = 8'(PAYLOAD_FLITS);
  localparam logic [7:0]  c_pay_last = 8'(PAYLOAD_FLITS - 1);
  localparam logic [7:0]  c_gap_last = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] c_to_last  = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  r_state;
  logic [0:0]  r_rx_state;
  logic [7:0]  r_pay_idx;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_rx_left;
  logic [15:0] r_to_cnt;
  logic [15:0] r_sent;
  logic [15:0] r_recv;
  logic [15:0] r_err;
  logic        r_timeout;

  logic        w_busy;
  logic        w_tx_val;
  logic        w_tx_fire;
  logic        w_rx_fire;
  logic        w_rx_hdr;
  logic        w_rx_eop;
  logic        w_hdr_err;
  logic        w_tx_eop;
  logic        w_start;
  logic        w_drain_ok;
  logic        w_to_expire;
  logic [2:0]  w_after_pkt;
  logic [15:0] w_recv_next;
  logic [63:0] w_hdr64;
  logic [63:0] w_pay64;
  logic [7:0]  w_rx_len;
  logic [7:0]  w_rx_msg;
  logic [7:0]  w_rx_mshr;
  logic        w_unused_rx;

  // Status and handshake outputs are pure decodes of registered state, so
  // neither tx_rdy nor rx_val has a combinational path to an output.
  assign w_busy   = (r_state == S_HDR) || (r_state == S_PAY) ||
                    (r_state == S_GAP) || (r_state == S_DRAIN);
  assign w_tx_val = (r_state == S_HDR) || (r_state == S_PAY);

  assign w_tx_fire = w_tx_val & noc.tx_rdy;
  assign w_rx_fire = w_busy & noc.rx_val;
  assign w_start   = start & ((r_state == S_IDLE) || (r_state == S_DONE));

  // The current packet index is the sent count; it only advances on the
  // final handshake of a packet, which keeps tx_data stable while stalled.
  assign w_hdr64 = {DEST_CHIPID, 8'd0, 8'd0, 4'b0010, c_pay_len,
                    TX_MSG_TYPE, r_sent[7:0], 6'd0};
  assign w_pay64 = {32'd0, r_sent, 8'd0, r_pay_idx};

  always_comb begin
    noc.tx_data = '0;
    if (r_state == S_HDR) begin
      noc.tx_data = NOC_DATA_WIDTH'(w_hdr64);
    end else if (r_state == S_PAY) begin
      noc.tx_data = NOC_DATA_WIDTH'(w_pay64);
    end
  end

  assign noc.tx_val = w_tx_val;
  assign noc.rx_rdy = w_busy;

  assign w_tx_eop = w_tx_fire &&
                    (((r_state == S_HDR) && (PAYLOAD_FLITS == 0)) ||
                     ((r_state == S_PAY) && (r_pay_idx == c_pay_last)));

  always_comb begin
    w_after_pkt = S_DONE;
    if (r_sent != c_last_pkt) begin
      w_after_pkt = (GAP_CYCLES > 0) ? S_GAP : S_HDR;
    end else if (EXPECT_RESP != 0) begin
      w_after_pkt = S_DRAIN;
    end
  end

  // Header field extraction for the returning channel.
  assign w_rx_len  = noc.rx_data[29:22];
  assign w_rx_msg  = noc.rx_data[21:14];
  assign w_rx_mshr = noc.rx_data[13:6];
  assign w_unused_rx = ^{noc.rx_data[NOC_DATA_WIDTH-1:30], noc.rx_data[5:0]};

  assign w_rx_hdr = w_rx_fire && (r_rx_state == RX_HDR);
  assign w_rx_eop = (w_rx_hdr && (w_rx_len == 8'd0)) ||
                    (w_rx_fire && (r_rx_state == RX_PAY) && (r_rx_left == 8'd1));
  // Responses are expected in order, so the receive count is the expected
  // MSHR. Any header beyond NUM_PKTS is an error regardless of content.
  assign w_hdr_err = w_rx_hdr && ((w_rx_msg != EXP_RX_MSG_TYPE) ||
                                  (w_rx_mshr != r_recv[7:0]) ||
                                  (r_recv >= c_num_pkts));

  // DRAIN looks at the post-increment receive count so that done rises the
  // cycle after the final rx flit rather than one cycle later.
  assign w_recv_next = r_recv + (w_rx_eop ? 16'd1 : 16'd0);
  assign w_drain_ok  = (w_recv_next >= c_num_pkts);
  assign w_to_expire = (r_state == S_DRAIN) && !w_rx_fire && (r_to_cnt == c_to_last);

  always_ff @(posedge chipset_clk) begin
    if (!chipset_rst_n) begin
      r_state    <= S_IDLE;
      r_rx_state <= RX_HDR;
      r_pay_idx  <= 8'd0;
      r_gap_cnt  <= 8'd0;
      r_rx_left  <= 8'd0;
      r_to_cnt   <= 16'd0;
      r_sent     <= 16'd0;
      r_recv     <= 16'd0;
      r_err      <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state    <= S_HDR;
            r_rx_state <= RX_HDR;
            r_pay_idx  <= 8'd0;
            r_gap_cnt  <= 8'd0;
            r_rx_left  <= 8'd0;
            r_to_cnt   <= 16'd0;
            r_sent     <= 16'd0;
            r_recv     <= 16'd0;
            r_err      <= 16'd0;
            r_timeout  <= 1'b0;
          end
        end
        S_HDR, S_PAY: begin
          if (w_tx_eop) begin
            r_sent    <= r_sent + 16'd1;
            r_state   <= w_after_pkt;
            r_gap_cnt <= 8'd0;
          end else if (w_tx_fire) begin
            r_state   <= S_PAY;
            r_pay_idx <= (r_state == S_HDR) ? 8'd0 : r_pay_idx + 8'd1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state   <= S_HDR;
            r_pay_idx <= 8'd0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (w_drain_ok) begin
            r_state <= S_DONE;
          end else if (w_to_expire) begin
            r_state   <= S_DONE;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Receive side only runs while busy, so it never collides with the
      // counter clear performed by an accepted start.
      if (w_rx_fire) begin
        r_to_cnt <= 16'd0;
      end else if (r_state == S_DRAIN) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end

      if (w_rx_hdr && (w_rx_len != 8'd0)) begin
        r_rx_state <= RX_PAY;
        r_rx_left  <= w_rx_len;
      end else if (w_rx_fire && (r_rx_state == RX_PAY)) begin
        r_rx_left <= r_rx_left - 8'd1;
        if (r_rx_left == 8'd1) begin
          r_rx_state <= RX_HDR;
        end
      end

      if (w_rx_eop) begin
        r_recv <= w_recv_next;
      end

      if (w_hdr_err && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);
  assign timeout    = r_timeout;
  assign sent_count = r_sent;
  assign recv_count = r_recv;
  assign err_count  = r_err;
  assign pass       = done && !r_timeout && (r_err == 16'd0) &&
                      ((r_recv == c_num_pkts) || (EXPECT_RESP == 0));

endmodule
`default_nettype wire

// File: tb/tb_chipset_noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_chipset_noc_traffic_gen
// Purpose  : Directed bench for chipset_noc_traffic_gen. Three instances:
//            A - default packet shape, TIMEOUT_CYCLES=50 (loopback, swap,
//                short-return timeout)
//            B - PAYLOAD_FLITS=2, GAP_CYCLES=3, NUM_PKTS=4 (payload, gaps,
//                mid-run reset)
//            C - EXPECT_RESP=0, NUM_PKTS=1 (no-response run, restart)
// Revision : 1.0 - initial release
// ============================================================================
module tb_chipset_noc_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, start_c;
  logic busy_a, done_a, pass_a, timeout_a;
  logic busy_b, done_b, pass_b, timeout_b;
  logic busy_c, done_c, pass_c, timeout_c;
  logic [15:0] sent_a, recv_a, err_a;
  logic [15:0] sent_b, recv_b, err_b;
  logic [15:0] sent_c, recv_c, err_c;

  chipset_noc_traffic_gen_if #(.NOC_DATA_WIDTH(64)) ifa ();
  chipset_noc_traffic_gen_if #(.NOC_DATA_WIDTH(64)) ifb ();
  chipset_noc_traffic_gen_if #(.NOC_DATA_WIDTH(64)) ifc ();

  chipset_noc_traffic_gen #(.TIMEOUT_CYCLES(50)) dut_a (
    .chipset_clk(clk), .chipset_rst_n(rst_n), .start(start_a), .noc(ifa),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
    .sent_count(sent_a), .recv_count(recv_a), .err_count(err_a));

  chipset_noc_traffic_gen #(.NUM_PKTS(4), .PAYLOAD_FLITS(2), .GAP_CYCLES(3)) dut_b (
    .chipset_clk(clk), .chipset_rst_n(rst_n), .start(start_b), .noc(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
    .sent_count(sent_b), .recv_count(recv_b), .err_count(err_b));

  chipset_noc_traffic_gen #(.NUM_PKTS(1), .EXPECT_RESP(0)) dut_c (
    .chipset_clk(clk), .chipset_rst_n(rst_n), .start(start_c), .noc(ifc),
    .busy(busy_c), .done(done_c), .pass(pass_c), .timeout(timeout_c),
    .sent_count(sent_c), .recv_count(recv_c), .err_count(err_c));

  typedef struct {
    logic [63:0] data;
    int          t;
  } flit_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  flit_t       qa[$];
  flit_t       qb[$];
  logic [63:0] txlog_a[$];
  logic [63:0] txlog_b[$];
  int          gaps_b[$];
  int          mode_a = 0;     // 0 loopback, 1 swap packets 4/5, 2 return 10 late
  int          a_ntx = 0;
  int          a_nrx = 0;
  int          last_rx_a = 0;
  int          idle_b = 0;
  logic        tog_b = 1'b0;

  // Expected header for chipid 0x2000, fbits 0010, message type 18.
  function automatic logic [63:0] hdr(int p, int len);
    return {14'b10000000000000, 8'd0, 8'd0, 4'b0010, 8'(len), 8'd18, 8'(p), 6'd0};
  endfunction

  function automatic logic [63:0] pay(int p, int k);
    return {32'd0, 16'(p), 16'(k)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Chip model for A: decisions at negedge apply to the coming posedge,
  // whose index is cyc+1. Returned flits become eligible 3 cycles later.
  initial begin
    flit_t f;
    logic [63:0] tmp;
    ifa.tx_rdy = 1'b1;
    ifa.rx_val = 1'b0;
    ifa.rx_data = '0;
    forever begin
      @(negedge clk);
      if (ifa.tx_val === 1'b1 && ifa.tx_rdy === 1'b1) begin
        txlog_a.push_back(ifa.tx_data);
        f.data = ifa.tx_data;
        f.t = cyc + 1;
        if (mode_a == 1 && a_ntx == 5 && qa.size() > 0) begin
          tmp = qa[qa.size()-1].data;
          qa[qa.size()-1].data = f.data;
          f.data = tmp;
        end
        qa.push_back(f);
        a_ntx++;
      end
      ifa.rx_val = 1'b0;
      ifa.rx_data = '0;
      if (qa.size() > 0 && qa[0].t + 3 <= cyc + 1 &&
          !(mode_a == 2 && (sent_a !== 16'd16 || a_nrx >= 10))) begin
        ifa.rx_val = 1'b1;
        ifa.rx_data = qa[0].data;
        if (ifa.rx_rdy === 1'b1) begin
          void'(qa.pop_front());
          a_nrx++;
          last_rx_a = cyc + 1;
        end
      end
    end
  end

  // Chip model for B: optional tx_rdy toggling, 1-cycle loopback, and
  // measurement of idle tx cycles between packets.
  initial begin
    flit_t f;
    ifb.tx_rdy = 1'b1;
    ifb.rx_val = 1'b0;
    ifb.rx_data = '0;
    forever begin
      @(negedge clk);
      ifb.tx_rdy = tog_b ? ~ifb.tx_rdy : 1'b1;
      if (busy_b === 1'b1 && ifb.tx_val === 1'b0) begin
        idle_b++;
      end else if (ifb.tx_val === 1'b1 && idle_b > 0) begin
        gaps_b.push_back(idle_b);
        idle_b = 0;
      end
      if (ifb.tx_val === 1'b1 && ifb.tx_rdy === 1'b1) begin
        txlog_b.push_back(ifb.tx_data);
        f.data = ifb.tx_data;
        f.t = cyc + 1;
        qb.push_back(f);
      end
      ifb.rx_val = 1'b0;
      ifb.rx_data = '0;
      if (qb.size() > 0 && qb[0].t + 1 <= cyc + 1) begin
        ifb.rx_val = 1'b1;
        ifb.rx_data = qb[0].data;
        if (ifb.rx_rdy === 1'b1) void'(qb.pop_front());
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ifc.tx_rdy = 1'b1; ifc.rx_val = 1'b0; ifc.rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({busy_a, done_a, pass_a, timeout_a, ifa.tx_val, ifa.rx_rdy} !== 6'b0)
      $display("FAIL reset_flags_a got %b want 000000", {busy_a, done_a, pass_a, timeout_a, ifa.tx_val, ifa.rx_rdy}); else n_pass++;
    n_chk++; if (ifa.tx_data !== 64'd0) $display("FAIL reset_txdata_a got %h want 0", ifa.tx_data); else n_pass++;
    n_chk++; if ({sent_a, recv_a, err_a} !== 48'd0) $display("FAIL reset_counts_a got %h want 0", {sent_a, recv_a, err_a}); else n_pass++;
    n_chk++; if ({busy_b, done_b, pass_b, ifb.tx_val, busy_c, done_c, ifc.tx_val} !== 7'b0)
      $display("FAIL reset_flags_bc got %b want 0000000", {busy_b, done_b, pass_b, ifb.tx_val, busy_c, done_c, ifc.tx_val}); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback();
    qa.delete(); txlog_a.delete(); mode_a = 0; a_ntx = 0; a_nrx = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n_chk++; if ({busy_a, ifa.tx_val} !== 2'b11) $display("FAIL start_latency got busy,val=%b want 11", {busy_a, ifa.tx_val}); else n_pass++;
    n_chk++; if (ifa.tx_data !== 64'h8000_0000_8004_8000) $display("FAIL first_header got %h want 8000000080048000", ifa.tx_data); else n_pass++;
    for (int i = 0; i < 300 && done_a !== 1'b1; i++) begin @(posedge clk); #1; end
    n_chk++; if (done_a !== 1'b1) $display("FAIL loop_done got %b want 1", done_a); else n_pass++;
    n_chk++; if ({sent_a, recv_a, err_a} !== {16'd16, 16'd16, 16'd0}) $display("FAIL loop_counts got %h want 001000100000", {sent_a, recv_a, err_a}); else n_pass++;
    n_chk++; if ({pass_a, timeout_a, busy_a} !== 3'b100) $display("FAIL loop_flags got pass,to,busy=%b want 100", {pass_a, timeout_a, busy_a}); else n_pass++;
    n_chk++; if (txlog_a.size() !== 16) $display("FAIL loop_txcount got %0d want 16", txlog_a.size()); else n_pass++;
    for (int i = 0; i < 16 && i < txlog_a.size(); i++) begin
      n_chk++; if (txlog_a[i] !== hdr(i, 0)) $display("FAIL loop_hdr%0d got %h want %h", i, txlog_a[i], hdr(i, 0)); else n_pass++;
    end
  endtask

  task automatic test_swap();
    qa.delete(); txlog_a.delete(); mode_a = 1; a_ntx = 0; a_nrx = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 300 && done_a !== 1'b1; i++) begin @(posedge clk); #1; end
    n_chk++; if (done_a !== 1'b1) $display("FAIL swap_done got %b want 1", done_a); else n_pass++;
    n_chk++; if (err_a !== 16'd2) $display("FAIL swap_err got %0d want 2", err_a); else n_pass++;
    n_chk++; if (recv_a !== 16'd16) $display("FAIL swap_recv got %0d want 16", recv_a); else n_pass++;
    n_chk++; if (pass_a !== 1'b0) $display("FAIL swap_pass got %b want 0", pass_a); else n_pass++;
  endtask

  task automatic test_timeout();
    int rise;
    rise = -1;
    qa.delete(); txlog_a.delete(); mode_a = 2; a_ntx = 0; a_nrx = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (timeout_a === 1'b1) begin rise = cyc; break; end
    end
    n_chk++; if (timeout_a !== 1'b1) $display("FAIL to_flag got %b want 1", timeout_a); else n_pass++;
    n_chk++; if (rise - last_rx_a !== 50) $display("FAIL to_delay got %0d want 50", rise - last_rx_a); else n_pass++;
    n_chk++; if ({done_a, pass_a} !== 2'b10) $display("FAIL to_done_pass got %b want 10", {done_a, pass_a}); else n_pass++;
    n_chk++; if (recv_a !== 16'd10) $display("FAIL to_recv got %0d want 10", recv_a); else n_pass++;
  endtask

  task automatic test_payload();
    qb.delete(); txlog_b.delete(); gaps_b.delete(); idle_b = 0; tog_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 300 && done_b !== 1'b1; i++) begin @(posedge clk); #1; end
    n_chk++; if (done_b !== 1'b1) $display("FAIL pay_done got %b want 1", done_b); else n_pass++;
    n_chk++; if ({sent_b, recv_b, err_b} !== {16'd4, 16'd4, 16'd0}) $display("FAIL pay_counts got %h want 000400040000", {sent_b, recv_b, err_b}); else n_pass++;
    n_chk++; if (pass_b !== 1'b1) $display("FAIL pay_pass got %b want 1", pass_b); else n_pass++;
    n_chk++; if (txlog_b.size() !== 12) $display("FAIL pay_txcount got %0d want 12", txlog_b.size()); else n_pass++;
    for (int p = 0; p < 4 && txlog_b.size() == 12; p++) begin
      n_chk++; if (txlog_b[3*p] !== hdr(p, 2)) $display("FAIL pay_hdr%0d got %h want %h", p, txlog_b[3*p], hdr(p, 2)); else n_pass++;
      n_chk++; if (txlog_b[3*p+1] !== pay(p, 0)) $display("FAIL pay_p%0d_k0 got %h want %h", p, txlog_b[3*p+1], pay(p, 0)); else n_pass++;
      n_chk++; if (txlog_b[3*p+2] !== pay(p, 1)) $display("FAIL pay_p%0d_k1 got %h want %h", p, txlog_b[3*p+2], pay(p, 1)); else n_pass++;
    end
    n_chk++; if (gaps_b.size() !== 3) $display("FAIL gap_count got %0d want 3", gaps_b.size()); else n_pass++;
    foreach (gaps_b[i]) begin
      n_chk++; if (gaps_b[i] < 3) $display("FAIL gap%0d got %0d want >=3", i, gaps_b[i]); else n_pass++;
    end
    tog_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    qb.delete(); txlog_b.delete(); tog_b = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ifb.tx_val === 1'b1 && ifb.tx_data === pay(1, 0)) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_chk++; if (found !== 1'b1) $display("FAIL rstmid_reach got %b want 1", found); else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({busy_b, done_b, pass_b, timeout_b, ifb.tx_val, ifb.rx_rdy} !== 6'b0)
      $display("FAIL rstmid_flags got %b want 000000", {busy_b, done_b, pass_b, timeout_b, ifb.tx_val, ifb.rx_rdy}); else n_pass++;
    n_chk++; if ({ifb.tx_data, sent_b, recv_b, err_b} !== 112'd0) $display("FAIL rstmid_data_counts got %h want 0", {ifb.tx_data, sent_b, recv_b, err_b}); else n_pass++;
    rst_n = 1'b1;
    qb.delete(); txlog_b.delete();
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n_chk++; if ({ifb.tx_val, ifb.tx_data} !== {1'b1, hdr(0, 2)}) $display("FAIL rstmid_restart got %h want %h", {ifb.tx_val, ifb.tx_data}, {1'b1, hdr(0, 2)}); else n_pass++;
    for (int i = 0; i < 300 && done_b !== 1'b1; i++) begin @(posedge clk); #1; end
    n_chk++; if ({done_b, pass_b, recv_b} !== {2'b11, 16'd4}) $display("FAIL rstmid_rerun got %h want 30004", {done_b, pass_b, recv_b}); else n_pass++;
  endtask

  task automatic test_noresp();
    ifc.tx_rdy = 1'b1;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    n_chk++; if ({ifc.tx_val, ifc.tx_data} !== {1'b1, hdr(0, 0)}) $display("FAIL noresp_hdr got %h want %h", {ifc.tx_val, ifc.tx_data}, {1'b1, hdr(0, 0)}); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if ({done_c, busy_c, pass_c, ifc.rx_rdy} !== 4'b1010) $display("FAIL noresp_done got done,busy,pass,rdy=%b want 1010", {done_c, busy_c, pass_c, ifc.rx_rdy}); else n_pass++;
    n_chk++; if ({sent_c, recv_c} !== {16'd1, 16'd0}) $display("FAIL noresp_counts got %h want 00010000", {sent_c, recv_c}); else n_pass++;
    ifc.rx_val = 1'b1;
    ifc.rx_data = hdr(0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({recv_c, err_c} !== 32'd0) $display("FAIL noresp_idle_rx got %h want 0", {recv_c, err_c}); else n_pass++;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    ifc.rx_val = 1'b0;
    n_chk++; if ({busy_c, recv_c, err_c} !== {1'b1, 32'd0}) $display("FAIL restart_rx_ignored got %h want 100000000", {busy_c, recv_c, err_c}); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if ({done_c, pass_c, recv_c} !== {2'b11, 16'd0}) $display("FAIL restart_done got %h want 30000", {done_c, pass_c, recv_c}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_swap();
    test_timeout();
    test_payload();
    test_reset_mid();
    test_noresp();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
